// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter stage for the clock datapath (hours/minutes/seconds).
// Supports cascade carry, per-digit manual adjust, validated load and 12h display mapping.
module bcd_mod_counter #(
  parameter int MOD       = 24,
  parameter bit MODE12_EN = 1'b1,
  parameter bit ADJ_EDGE  = 1'b1
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       EN,
  input  logic       mode,
  input  logic       increUnit,
  input  logic       increTen,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] Q,
  output logic [6:0] bin,
  output logic [7:0] disp,
  output logic       noon,
  output logic       CO,
  output logic       ld_err
);

  localparam logic [7:0] LAST = 8'(MOD - 1);
  localparam bit         M12  = MODE12_EN && (MOD == 24);

  logic [3:0] t_q, t_d, u_q, u_d;
  logic       err_q, err_d;
  logic       pu_q, pt_q;
  logic [7:0] v;
  logic       adj_u, adj_t, ld_ok;
  logic [3:0] t1, u1, tn, hv;
  logic [7:0] base, lim;

  function automatic logic [7:0] x10(input logic [3:0] d);
    return ({4'd0, d} << 3) + ({4'd0, d} << 1);
  endfunction

  assign v     = x10(t_q) + {4'd0, u_q};
  assign adj_u = ADJ_EDGE ? (increUnit & ~pu_q) : increUnit;
  assign adj_t = ADJ_EDGE ? (increTen & ~pt_q) : increTen;
  assign ld_ok = (ld_val[3:0] <= 4'd9) && (ld_val[7:4] <= 4'd9) &&
                 ((x10(ld_val[7:4]) + {4'd0, ld_val[3:0]}) <= LAST);

  always_comb begin
    t_d   = t_q;
    u_d   = u_q;
    err_d = 1'b0;
    t1    = t_q;
    u1    = u_q;
    tn    = 4'd0;
    base  = 8'd0;
    lim   = 8'd0;
    if (ld) begin
      if (ld_ok) begin
        t_d = ld_val[7:4];
        u_d = ld_val[3:0];
      end else begin
        err_d = 1'b1;
      end
    end else if (adj_u || adj_t) begin
      // Units step resolves first; the tens step then sees its result.
      if (adj_u) begin
        u1 = ((u_q == 4'd9) || ((v + 8'd1) > LAST)) ? 4'd0 : u_q + 4'd1;
      end
      t_d = t1;
      u_d = u1;
      if (adj_t) begin
        tn   = t1 + 4'd1;
        base = x10(tn);
        if (base <= LAST) begin
          lim = LAST - base;
          t_d = tn;
          u_d = ({4'd0, u1} <= lim) ? u1 : lim[3:0];
        end else begin
          t_d = 4'd0;
        end
      end
    end else if (EN) begin
      if (v == LAST) begin
        t_d = 4'd0;
        u_d = 4'd0;
      end else if (u_q == 4'd9) begin
        t_d = t_q + 4'd1;
        u_d = 4'd0;
      end else begin
        u_d = u_q + 4'd1;
      end
    end
  end

  // Previous-sample registers reset high so a button held through reset is not an edge.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      t_q   <= 4'd0;
      u_q   <= 4'd0;
      err_q <= 1'b0;
      pu_q  <= 1'b1;
      pt_q  <= 1'b1;
    end else begin
      t_q   <= t_d;
      u_q   <= u_d;
      err_q <= err_d;
      pu_q  <= increUnit;
      pt_q  <= increTen;
    end
  end

  assign Q      = {t_q, u_q};
  assign bin    = v[6:0];
  assign ld_err = err_q;
  assign CO     = EN & (v == LAST) & ~ld & ~adj_u & ~adj_t;

  // V-12 only matters for V in 13..23, where the low nibble arithmetic is exact.
  assign hv = v[3:0] - 4'd12;

  always_comb begin
    disp = Q;
    noon = 1'b0;
    if (M12 && !mode) begin
      if (v == 8'd0) begin
        disp = 8'h12;
      end else if (v == 8'd12) begin
        disp = 8'h12;
        noon = 1'b1;
      end else if (v > 8'd12) begin
        noon = 1'b1;
        disp = (hv >= 4'd10) ? {4'd1, hv - 4'd10} : {4'd0, hv};
      end
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: three parameterisations share one stimulus stream and are
// checked every cycle against an arithmetic reference model, plus directed scenario checks.
module tb_bcd_mod_counter;

  localparam int MODS[3] = '{24, 60, 7};
  localparam bit EDG[3]  = '{1'b1, 1'b1, 1'b0};
  localparam bit M12S[3] = '{1'b1, 1'b1, 1'b0};

  logic       CP, rst_n, en, md, iu, it, ld;
  logic [7:0] lv;
  logic [7:0] q_o[3], disp_o[3];
  logic [6:0] bin_o[3];
  logic       noon_o[3], co_o[3], err_o[3];

  int n_cmp = 0;
  int n_err = 0;

  int mv[3];
  bit merr[3], mpu[3], mpt[3];

  bcd_mod_counter #(.MOD(24), .MODE12_EN(1'b1), .ADJ_EDGE(1'b1)) u_h24 (
    .CP(CP), .reset(rst_n), .EN(en), .mode(md), .increUnit(iu), .increTen(it),
    .ld(ld), .ld_val(lv), .Q(q_o[0]), .bin(bin_o[0]), .disp(disp_o[0]),
    .noon(noon_o[0]), .CO(co_o[0]), .ld_err(err_o[0]));

  bcd_mod_counter #(.MOD(60), .MODE12_EN(1'b1), .ADJ_EDGE(1'b1)) u_m60 (
    .CP(CP), .reset(rst_n), .EN(en), .mode(md), .increUnit(iu), .increTen(it),
    .ld(ld), .ld_val(lv), .Q(q_o[1]), .bin(bin_o[1]), .disp(disp_o[1]),
    .noon(noon_o[1]), .CO(co_o[1]), .ld_err(err_o[1]));

  bcd_mod_counter #(.MOD(7), .MODE12_EN(1'b0), .ADJ_EDGE(1'b0)) u_m7 (
    .CP(CP), .reset(rst_n), .EN(en), .mode(md), .increUnit(iu), .increTen(it),
    .ld(ld), .ld_val(lv), .Q(q_o[2]), .bin(bin_o[2]), .disp(disp_o[2]),
    .noon(noon_o[2]), .CO(co_o[2]), .ld_err(err_o[2]));

  // Clock block
  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int x);
    return 8'((x / 10) * 16 + (x % 10));
  endfunction

  function automatic bit m_adj_u(input int i);
    return EDG[i] ? (iu && !mpu[i]) : bit'(iu);
  endfunction

  function automatic bit m_adj_t(input int i);
    return EDG[i] ? (it && !mpt[i]) : bit'(it);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0; merr[i] = 1'b0; mpu[i] = 1'b1; mpt[i] = 1'b1;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int lo, hi, t, u;
      bit au, at;
      au = m_adj_u(i);
      at = m_adj_t(i);
      lo = int'(lv[3:0]);
      hi = int'(lv[7:4]);
      if (ld) begin
        if (lo <= 9 && hi <= 9 && hi * 10 + lo <= MODS[i] - 1) begin
          mv[i] = hi * 10 + lo;
          merr[i] = 1'b0;
        end else begin
          merr[i] = 1'b1;
        end
      end else begin
        merr[i] = 1'b0;
        if (au || at) begin
          t = mv[i] / 10;
          u = mv[i] % 10;
          if (au) u = (u == 9 || mv[i] + 1 > MODS[i] - 1) ? 0 : u + 1;
          if (at) begin
            if (10 * (t + 1) <= MODS[i] - 1) begin
              t = t + 1;
              if (u > MODS[i] - 1 - 10 * t) u = MODS[i] - 1 - 10 * t;
            end else begin
              t = 0;
            end
          end
          mv[i] = 10 * t + u;
        end else if (en) begin
          mv[i] = (mv[i] + 1) % MODS[i];
        end
      end
      mpu[i] = iu;
      mpt[i] = it;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d;
      bit n, co;
      int h;
      if (MODS[i] == 24 && M12S[i] && !md) begin
        h = mv[i] % 12;
        if (h == 0) h = 12;
        d = to_bcd(h);
        n = (mv[i] >= 12);
      end else begin
        d = to_bcd(mv[i]);
        n = 1'b0;
      end
      co = en && (mv[i] == MODS[i] - 1) && !ld && !m_adj_u(i) && !m_adj_t(i);
      check_eq($sformatf("u%0d.q", i), q_o[i], to_bcd(mv[i]));
      check_eq($sformatf("u%0d.bin", i), bin_o[i], mv[i]);
      check_eq($sformatf("u%0d.disp", i), disp_o[i], d);
      check_eq($sformatf("u%0d.noon", i), noon_o[i], n);
      check_eq($sformatf("u%0d.co", i), co_o[i], co);
      check_eq($sformatf("u%0d.ld_err", i), err_o[i], merr[i]);
    end
  endtask

  // Driver: inputs change on the falling edge, outputs checked 1 unit later.
  task automatic cycle(input bit e, input bit u, input bit t, input bit l,
                       input logic [7:0] v, input bit m);
    en = e; iu = u; it = t; ld = l; lv = v; md = m;
    #1;
    check_all();
    @(posedge CP);
    model_step();
    @(negedge CP);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge CP);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] sweep_v[5] = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h23};
    logic [7:0] sweep_d[5] = '{8'h12, 8'h11, 8'h12, 8'h01, 8'h11};
    bit         sweep_n[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit         rm;
    logic [7:0] rv;

    rst_n = 1'b0; en = 0; md = 1; iu = 0; it = 0; ld = 0; lv = 8'h00;
    model_reset();
    #1;
    check_all();
    @(negedge CP);
    rst_n = 1'b1;

    // Full 24h count sweep with wrap.
    repeat (23) cycle(1, 0, 0, 0, 8'h00, 1);
    check_eq("h24.q23", q_o[0], 8'h23);
    check_eq("h24.co23", co_o[0], 1'b1);
    cycle(1, 0, 0, 0, 8'h00, 1);
    check_eq("h24.wrap", q_o[0], 8'h00);

    // Tens adjust with units clamp, tens wrap, and held-button single step.
    cycle(0, 0, 0, 1, 8'h15, 1);
    check_eq("h24.ld15", q_o[0], 8'h15);
    cycle(0, 0, 1, 0, 8'h00, 1);
    check_eq("h24.ten_clamp", q_o[0], 8'h23);
    cycle(0, 0, 0, 0, 8'h00, 1);
    cycle(0, 0, 1, 0, 8'h00, 1);
    check_eq("h24.ten_wrap", q_o[0], 8'h03);
    cycle(0, 0, 0, 0, 8'h00, 1);
    repeat (10) cycle(0, 0, 1, 0, 8'h00, 1);
    check_eq("h24.ten_hold", q_o[0], 8'h13);
    cycle(0, 0, 0, 1, 8'h23, 1);
    cycle(0, 1, 0, 0, 8'h00, 1);
    check_eq("h24.unit_wrap", q_o[0], 8'h20);
    cycle(0, 0, 0, 0, 8'h00, 1);

    // 12h display mapping.
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 0, 1, sweep_v[k], 0);
      check_eq($sformatf("h12.disp%0h", sweep_v[k]), disp_o[0], sweep_d[k]);
      check_eq($sformatf("h12.noon%0h", sweep_v[k]), noon_o[0], sweep_n[k]);
    end
    cycle(0, 0, 0, 1, 8'h15, 0);
    check_eq("h12.disp15", disp_o[0], 8'h03);
    cycle(0, 0, 0, 0, 8'h00, 1);
    check_eq("h24.disp15", disp_o[0], 8'h15);
    check_eq("h24.q15", q_o[0], 8'h15);

    // Minutes stage: adjust beats count at terminal value.
    cycle(0, 0, 0, 1, 8'h59, 1);
    cycle(1, 1, 0, 0, 8'h00, 1);
    check_eq("m60.adj_over_cnt", q_o[1], 8'h50);
    cycle(1, 0, 0, 0, 8'h00, 1);
    check_eq("m60.cnt51", q_o[1], 8'h51);

    // Load validation.
    cycle(0, 0, 0, 1, 8'h47, 1);
    check_eq("m60.ld47", q_o[1], 8'h47);
    check_eq("m60.ld47_err", err_o[1], 1'b0);
    cycle(0, 0, 0, 1, 8'h60, 1);
    check_eq("m60.ld60_q", q_o[1], 8'h47);
    check_eq("m60.ld60_err", err_o[1], 1'b1);
    cycle(0, 0, 0, 0, 8'h00, 1);
    check_eq("m60.err_pulse", err_o[1], 1'b0);
    cycle(0, 0, 0, 1, 8'h3A, 1);
    check_eq("m60.ld3a_q", q_o[1], 8'h47);
    check_eq("m60.ld3a_err", err_o[1], 1'b1);
    cycle(0, 0, 0, 1, 8'h59, 1);
    cycle(1, 0, 0, 1, 8'h10, 1);
    check_eq("m60.ld_over_cnt", q_o[1], 8'h10);

    // Asynchronous reset mid-cycle with the units button held through release.
    cycle(0, 0, 0, 1, 8'h34, 1);
    en = 1; iu = 1; ld = 0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("m60.async_rst", q_o[1], 8'h00);
    model_reset();
    check_all();
    @(negedge CP);
    rst_n = 1'b1;
    cycle(0, 1, 0, 0, 8'h00, 1);
    check_eq("m60.held_no_adj", q_o[1], 8'h00);

    // Randomized traffic against the model.
    rm = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) rm = ~rm;
      rv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : to_bcd($urandom_range(0, 65));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 12) == 0, rv, rm);
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised two-digit BCD modulo counter for the clock datapath. One block covers hours (MOD=24), minutes and seconds (MOD=60).
- Features: cascade carry, per-digit manual adjust with edge detection, validated parallel load, and a 12h display mode with a correct 12 AM/12 PM mapping.
- Chained via CO into the next stage's EN. Outputs drive the BCD-to-7-segment scan logic.

Parameters:
MOD, 24, modulus; legal 2..99; count range 0..MOD-1
MODE12_EN, 1, 1 enables 12h display conversion; honoured only when MOD==24, otherwise treated as 0
ADJ_EDGE, 1, 1: increUnit/increTen act on rising edge only; 0: one step per cycle while high

Ports:
CP  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
EN  input  1  count enable (carry-in from previous stage)
mode  input  1  1 = 24h display, 0 = 12h display
increUnit  input  1  manual adjust, units digit
increTen  input  1  manual adjust, tens digit
ld  input  1  synchronous load strobe
ld_val  input  8  BCD load value {tens[7:4], units[3:0]}
Q  output  8  registered BCD count {T, U}
bin  output  7  binary count V = 10*T + U
disp  output  8  BCD display value (12h-converted when active)
noon  output  1  PM flag (12h mode only)
CO  output  1  carry-out / terminal count
ld_err  output  1  one-cycle pulse: load rejected

Behaviour:
- State: T[3:0], U[3:0], ld_err register, and previous-sample registers pU and pT for the adjust inputs. Invariant: U<=9, V<=MOD-1.
- Reset (reset=0, async): T=U=0, ld_err=0, pU=pT=1. Because pU/pT reset to 1, an input held high through reset release is not an edge.
- Adjust events:
  - ADJ_EDGE=1: adjU = increUnit & ~pU; adjT = increTen & ~pT.
  - ADJ_EDGE=0: adjU = increUnit; adjT = increTen.
  - pU/pT sample their inputs every cycle.
- Per-cycle priority: ld > adjust > count.
  - ld=1: accept if ld_val[3:0]<=9, ld_val[7:4]<=9 and value<=MOD-1. On reject, the count holds and ld_err=1 next cycle. Adjust and count are ignored that cycle.
  - Else, if adjU or adjT, no count that cycle:
    - Units step: U' = 0 if U==9 or V+1>MOD-1, else U+1. T unchanged, no carry.
    - Tens step: if 10*(T+1)<=MOD-1, then T'=T+1 and U'=min(U, MOD-1-10*(T+1)). Else T'=0, U unchanged.
    - Both in the same cycle: apply the units step first, then the tens step to that result.
  - Else, if EN: V' = V+1, or 0 when V==MOD-1.
- CO (combinational) = EN & (V==MOD-1) & ~ld & ~adjU & ~adjT.
- ld_err is registered and high for exactly one cycle per rejected load.
- bin and Q are combinational from the T/U registers. Count latency is 1 cycle.
- Display, when 12h is active (MODE12_EN effective and mode=0):
  - V=0 → disp=8'h12, noon=0.
  - V=1..11 → disp=BCD(V), noon=0.
  - V=12 → disp=8'h12, noon=1.
  - V=13..23 → disp=BCD(V-12), noon=1.
- Otherwise: disp=Q, noon=0.
- disp and noon are combinational. A mode change takes effect the same cycle and does not alter the count.
- Reset asserted mid-operation clears state immediately. The first count occurs on the first CP edge after release with EN=1.

Test Plan:
- MOD=24: reset, EN=1 for 25 cycles → Q 00..23 then 00. CO=1 only during the cycle with Q=23. disp/bin track Q in 24h.
- MOD=24, mode=0: sweep V through 00, 11, 12, 13, 23 → disp/noon = 12/0, 11/0, 12/1, 01/1, 11/1. Toggling mode at V=15 changes disp 15↔03 with Q unchanged.
- MOD=24, Q=15, one increTen pulse → Q=23 (U clamped 5→3). Another pulse → Q=03. At Q=23, increUnit pulse → Q=20. increTen held high 10 cycles with ADJ_EDGE=1 → exactly one step.
- MOD=60, Q=59, EN=1 and increUnit edge in the same cycle → Q=50, CO=0, no wrap to 00. Next cycle EN only → Q=51.
- MOD=60: ld_val=8'h47 → Q=47, ld_err=0. ld_val=8'h60 → Q unchanged, ld_err pulses 1 cycle. ld_val=8'h3A → rejected. ld with EN=1 at Q=59 → load wins, CO=0.
- MOD=60, EN=1: assert reset asynchronously between CP edges at Q=34 → Q=00 before the next edge. Hold increUnit=1 across release → no adjust step.
